rd53_afe_tot_core: RTL and testbench
====================================

RD53_AFE_TOT_CORE -- requirements
Module: rd53_afe_tot_core

Interface
REQ-001 SHALL have parameter NCH, default 8: number of front-end channels (2..64).
REQ-002 SHALL have parameter TOT_W, default 4: ToT counter width (2..8).
REQ-003 SHALL have parameter INJ_W, default 4: injection pulse-width field width.
REQ-004 SHALL have ports: clk (in, 1): sole clock. rst_n (in, 1): asynchronous, active-low reset.
REQ-005 SHALL have port disc_n (in, NCH): discriminator outputs, negative polarity, asynchronous to clk.
REQ-006 SHALL have port en_mask (in, NCH): per-channel enable, 1 = enabled.
REQ-007 SHALL have ports inj_trig (in, 1): injection request. inj_width (in, INJ_W): phase length minus one.
REQ-008 SHALL have ports cal_s0 and cal_s1 (out, 1 each): injection switch controls.
REQ-009 SHALL have ports hit_valid (out, 1), hit_ready (in, 1), hit_ch (out, clog2(NCH)) and hit_tot (out, TOT_W).
REQ-010 SHALL have port lost_cnt (out, 8): count of hits lost to channel busy.

Function
REQ-011 SHALL synchronize each disc_n bit through two flops; "active" means synchronized value 0.
REQ-012 SHALL run a per-channel FSM with states IDLE, COUNT and HOLD.
REQ-013 IDLE->COUNT SHALL occur on an inactive->active transition of an enabled channel, with ToT counter = 1 on that cycle.
REQ-014 In COUNT, the counter SHALL increment each cycle the channel stays active, saturating at 2^TOT_W-1.
REQ-015 COUNT->HOLD SHALL occur on the first inactive cycle; the counter value SHALL be latched as the hit ToT.
REQ-016 HOLD->IDLE SHALL occur on the cycle the channel's hit is transferred into the output register.
REQ-017 An active transition while in HOLD SHALL drop the new hit and increment lost_cnt, saturating at 255.
REQ-018 Clearing en_mask during COUNT SHALL abort to IDLE with no hit. In HOLD, the held hit SHALL still be read out.
REQ-019 The arbiter SHALL grant the lowest-index channel in HOLD when the output register is empty or is being consumed (hit_valid and hit_ready) in that cycle.
REQ-020 hit_ch, hit_tot and hit_valid SHALL be registered and SHALL hold stable while hit_valid=1 and hit_ready=0.
REQ-021 With the output empty, hit_valid SHALL rise 4 clk edges after the disc_n rising edge is captured: 2 sync, 1 FSM, 1 output.
REQ-022 Back-to-back grants SHALL sustain one hit per cycle while hit_ready=1.

Reset
REQ-023 rst_n low SHALL immediately force: all FSMs to IDLE, counters and sync flops to inactive, hit_valid/hit_ch/hit_tot/lost_cnt to 0, cal_s0/cal_s1 to 0, injection sequencer to idle. Reset mid-count or mid-injection SHALL discard all state.

Configuration
REQ-024 With AFE_INJ_EN defined, a rising edge on inj_trig while the sequencer is idle SHALL:
- drive cal_s0=1 for inj_width+1 cycles, starting the next cycle;
- then drive cal_s1=1 for inj_width+1 cycles;
- then return to idle.
Triggers while busy SHALL be ignored.
REQ-025 Without AFE_INJ_EN, cal_s0 and cal_s1 SHALL be constant 0, inj_trig SHALL be ignored, and no sequencer logic SHALL be present.

Structure
REQ-026 Package rd53_afe_pkg SHALL hold the FSM state enum, the TOT_MAX function of TOT_W, and the injection-sequencer state enum.
REQ-027 Per-channel sync, FSM and counter SHALL be the sub-module rd53_afe_tot_chan, instantiated NCH times. The arbiter, output register, lost counter and injection sequencer SHALL reside in the top level.

Verification
REQ-028 Hold ch3 disc_n low for 6 cycles, hit_ready=1 -> one hit: ch=3, tot=6; hit_valid rises 4 edges after disc_n returns high.
REQ-029 With TOT_W=4, hold disc_n low for 40 cycles -> tot=15.
REQ-030 Release ch1 and ch5 on the same cycle with hit_ready=0 for 10 cycles -> ch1 is presented stable throughout, then ch5 on the cycle after the first handshake.
REQ-031 Fire two pulses on ch2 while its first hit is in HOLD with hit_ready=0 -> lost_cnt=1; only the first hit is read out.
REQ-032 With AFE_INJ_EN, inj_width=2, pulse inj_trig -> cal_s0 high 3 cycles, then cal_s1 high 3 cycles. A second trigger mid-sequence has no effect.
REQ-033 Assert rst_n low mid-count on ch0 and mid-injection -> all outputs 0 immediately; no hit is emitted after release.

Source files
------------

// File: rtl/rd53_afe_pkg.sv
// rd53_afe_pkg: channel/injection state types and ToT saturation helper
package rd53_afe_pkg;
  typedef enum logic [1:0] {CH_IDLE, CH_COUNT, CH_HOLD} chan_state_t;
  typedef enum logic [1:0] {INJ_IDLE, INJ_S0, INJ_S1} inj_state_t;
  function automatic int tot_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/rd53_afe_tot_chan.sv
// rd53_afe_tot_chan: one front-end channel -- disc sync, ToT FSM and counter
module rd53_afe_tot_chan
  import rd53_afe_pkg::*;
#(
  parameter int TOT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disc_n,
  input  logic             en,
  input  logic             gnt,
  output logic             hold,
  output logic             lost,
  output logic [TOT_W-1:0] tot
);
  localparam logic [TOT_W-1:0] TMAX = TOT_W'(tot_max(TOT_W));
  logic s1, s2, act_d, act, rise;
  chan_state_t state;
  assign act = ~s2;
  assign rise = act & ~act_d;
  assign hold = state == CH_HOLD;
  assign lost = hold & rise;
  // two-flop synchronizer on the async discriminator, plus one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, act_d} <= 3'b110;
    else {s1, s2, act_d} <= {disc_n, s1, act};
  // ToT FSM; tot keeps the latched value while the hit waits in HOLD
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CH_IDLE;
      tot <= '0;
    end else begin
      case (state)
        CH_IDLE: if (en && rise) begin
          state <= CH_COUNT;
          tot <= TOT_W'(1);
        end
        CH_COUNT: if (!en) begin
          state <= CH_IDLE;
          tot <= '0;
        end else if (act) tot <= (tot == TMAX) ? tot : tot + TOT_W'(1);
        else state <= CH_HOLD;
        CH_HOLD: if (gnt) state <= CH_IDLE;
        default: state <= CH_IDLE;
      endcase
    end
endmodule

// File: rtl/rd53_afe_tot_core.sv
// rd53_afe_tot_core: NCH ToT channels, lowest-index arbiter, output register, lost counter; AFE_INJ_EN adds the injection sequencer
module rd53_afe_tot_core
  import rd53_afe_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int TOT_W = 4,
  parameter int INJ_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         disc_n,
  input  logic [NCH-1:0]         en_mask,
  input  logic                   inj_trig,
  input  logic [INJ_W-1:0]       inj_width,
  output logic                   cal_s0,
  output logic                   cal_s1,
  output logic                   hit_valid,
  input  logic                   hit_ready,
  output logic [$clog2(NCH)-1:0] hit_ch,
  output logic [TOT_W-1:0]       hit_tot,
  output logic [7:0]             lost_cnt
);
  localparam int CW = $clog2(NCH);
  logic [NCH-1:0] hold, lost, gnt;
  logic [NCH-1:0][TOT_W-1:0] tot;
  logic [CW-1:0] sel;
  logic any, load;
  logic [8:0] lost_sum;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    rd53_afe_tot_chan #(.TOT_W(TOT_W)) u_chan (
      .clk(clk), .rst_n(rst_n), .disc_n(disc_n[i]), .en(en_mask[i]),
      .gnt(gnt[i]), .hold(hold[i]), .lost(lost[i]), .tot(tot[i])
    );
  end
  // lowest-index channel in HOLD wins
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) if (hold[i]) begin
      sel = CW'(i);
      any = 1'b1;
    end
  end
  assign load = ~hit_valid | hit_ready;
  assign gnt = (any && load) ? NCH'(1) << sel : '0;
  // several channels can drop a hit in the same cycle
  always_comb begin
    lost_sum = {1'b0, lost_cnt};
    for (int i = 0; i < NCH; i++) lost_sum = lost_sum + 9'(lost[i]);
  end
  // output register refills whenever it is empty or being consumed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_valid <= 1'b0;
      hit_ch <= '0;
      hit_tot <= '0;
    end else if (load) begin
      hit_valid <= any;
      if (any) begin
        hit_ch <= sel;
        hit_tot <= tot[sel];
      end
    end
  // saturating count of hits dropped because the channel was still holding one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lost_cnt <= '0;
    else lost_cnt <= lost_sum[8] ? 8'hff : lost_sum[7:0];
`ifdef AFE_INJ_EN
  inj_state_t inj_st;
  logic inj_d;
  logic [INJ_W-1:0] inj_cnt, inj_len;
  // two-phase calibration pulse: cal_s0 then cal_s1, each inj_len+1 cycles; retriggers while busy are ignored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inj_st <= INJ_IDLE;
      inj_d <= 1'b0;
      inj_cnt <= '0;
      inj_len <= '0;
      cal_s0 <= 1'b0;
      cal_s1 <= 1'b0;
    end else begin
      inj_d <= inj_trig;
      case (inj_st)
        INJ_IDLE: if (inj_trig && !inj_d) begin
          inj_st <= INJ_S0;
          inj_len <= inj_width;
          inj_cnt <= '0;
          cal_s0 <= 1'b1;
        end
        INJ_S0: if (inj_cnt == inj_len) begin
          inj_st <= INJ_S1;
          inj_cnt <= '0;
          cal_s0 <= 1'b0;
          cal_s1 <= 1'b1;
        end else inj_cnt <= inj_cnt + INJ_W'(1);
        INJ_S1: if (inj_cnt == inj_len) begin
          inj_st <= INJ_IDLE;
          cal_s1 <= 1'b0;
        end else inj_cnt <= inj_cnt + INJ_W'(1);
        default: inj_st <= INJ_IDLE;
      endcase
    end
`else
  logic unused_inj;
  assign unused_inj = ^{inj_trig, inj_width};
  assign cal_s0 = 1'b0;
  assign cal_s1 = 1'b0;
`endif
endmodule

// File: tb/tb_rd53_afe_tot_core.sv
// tb_rd53_afe_tot_core: scoreboard bench for the ToT core with directed and randomized pulses
module tb_rd53_afe_tot_core;
  localparam int NCH = 8, TOT_W = 4, INJ_W = 4;
  localparam int TMAX = (1 << TOT_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NCH-1:0] disc_n, en_mask;
  logic inj_trig, hit_ready, cal_s0, cal_s1, hit_valid;
  logic [INJ_W-1:0] inj_width;
  logic [$clog2(NCH)-1:0] hit_ch;
  logic [TOT_W-1:0] hit_tot;
  logic [7:0] lost_cnt;
  typedef struct {int ch; int tot;} hit_t;
  hit_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int len[NCH];
  int mx, w, lat;
  logic seen;
  logic [NCH-1:0] m;
  always #5 clk = ~clk;
  rd53_afe_tot_core #(.NCH(NCH), .TOT_W(TOT_W), .INJ_W(INJ_W)) dut (
    .clk(clk), .rst_n(rst_n), .disc_n(disc_n), .en_mask(en_mask),
    .inj_trig(inj_trig), .inj_width(inj_width), .cal_s0(cal_s0), .cal_s1(cal_s1),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_ch(hit_ch),
    .hit_tot(hit_tot), .lost_cnt(lost_cnt)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int ch, input int l);
    hit_t e;
    e.ch = ch;
    e.tot = (l > TMAX) ? TMAX : l;
    exp_q.push_back(e);
  endtask
  task automatic pulse(input int ch, input int l);
    disc_n[ch] = 1'b0;
    repeat (l) tick();
    disc_n[ch] = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic pv;
    logic [$clog2(NCH)-1:0] pch;
    logic [TOT_W-1:0] ptot;
    hit_t e;
    pv = 1'b0;
    pch = '0;
    ptot = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 1'b0;
      else begin
        if (pv) begin
          chk("stall_valid", hit_valid, 1);
          chk("stall_ch", hit_ch, pch);
          chk("stall_tot", hit_tot, ptot);
        end
        if (hit_valid && hit_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_hit: got ch %0d tot %0d, expected no hit", hit_ch, hit_tot);
          end else begin
            e = exp_q.pop_front();
            chk("hit_ch", hit_ch, e.ch);
            chk("hit_tot", hit_tot, e.tot);
          end
        end
        pv = hit_valid && !hit_ready;
        pch = hit_ch;
        ptot = hit_tot;
      end
    end
  end
  initial begin
    disc_n = '1;
    en_mask = '1;
    hit_ready = 1'b1;
    inj_trig = 1'b0;
    inj_width = INJ_W'(2);
    #12;
    chk("rst_valid", hit_valid, 0);
    chk("rst_ch", hit_ch, 0);
    chk("rst_tot", hit_tot, 0);
    chk("rst_lost", lost_cnt, 0);
    chk("rst_cal", {cal_s0, cal_s1}, 0);
    #10 rst_n = 1'b1;
    repeat (3) tick();
    push(3, 6);
    pulse(3, 6);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (hit_valid) begin
        lat = n;
        break;
      end
    end
    chk("latency_edges", lat, 4);
    repeat (5) tick();
    push(4, 40);
    pulse(4, 40);
    repeat (8) tick();
    hit_ready = 1'b0;
    push(1, 5);
    push(5, 5);
    disc_n[1] = 1'b0;
    disc_n[5] = 1'b0;
    repeat (5) tick();
    disc_n = '1;
    repeat (4) tick();
    repeat (10) begin
      @(negedge clk);
      chk("stall_is_valid", hit_valid, 1);
      chk("stall_is_ch1", hit_ch, 1);
    end
    @(posedge clk);
    #1 hit_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_valid", hit_valid, 1);
    chk("b2b_ch5", hit_ch, 5);
    repeat (4) tick();
    for (int r = 0; r < 25; r++) begin
      m = NCH'($urandom);
      en_mask = m;
      mx = 0;
      for (int i = 0; i < NCH; i++) begin
        len[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 24));
        if (len[i] > mx) mx = len[i];
      end
      for (int i = 0; i < NCH; i++) if (m[i] && len[i] > 0) push(i, len[i]);
      for (int c = 0; c < mx; c++) begin
        for (int i = 0; i < NCH; i++) disc_n[i] = !(len[i] > 0 && c >= mx - len[i]);
        hit_ready = 1'($urandom_range(0, 1));
        tick();
      end
      disc_n = '1;
      w = 0;
      while ((exp_q.size() > 0 || hit_valid) && w < 400) begin
        hit_ready = 1'($urandom_range(0, 1));
        tick();
        w++;
      end
      chk("drain_in_time", w < 400, 1);
      hit_ready = 1'b1;
      repeat (6) tick();
    end
    en_mask = '1;
    hit_ready = 1'b0;
    push(0, 3);
    pulse(0, 3);
    repeat (6) tick();
    push(2, 4);
    pulse(2, 4);
    repeat (6) tick();
    pulse(2, 2);
    repeat (6) tick();
    chk("lost_cnt", lost_cnt, 1);
    hit_ready = 1'b1;
    repeat (10) tick();
    chk("lost_cnt_kept", lost_cnt, 1);
    chk("lost_q_empty", exp_q.size(), 0);
`ifdef AFE_INJ_EN
    inj_trig = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("cal_s0_seq", cal_s0, k < 3);
      chk("cal_s1_seq", cal_s1, k >= 3 && k < 6);
      if (k == 1) inj_trig = 1'b0;
      if (k == 2) inj_trig = 1'b1;
    end
`else
    inj_trig = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("cal_off", {cal_s0, cal_s1}, 0);
    end
`endif
    inj_trig = 1'b0;
    repeat (3) tick();
    disc_n[0] = 1'b0;
    repeat (2) tick();
`ifdef AFE_INJ_EN
    inj_trig = 1'b1;
`endif
    repeat (2) tick();
`ifdef AFE_INJ_EN
    chk("cal_s0_before_rst", cal_s0, 1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_valid", hit_valid, 0);
    chk("rst2_ch_tot", {hit_ch, hit_tot}, 0);
    chk("rst2_lost", lost_cnt, 0);
    chk("rst2_cal", {cal_s0, cal_s1}, 0);
    disc_n = '1;
    inj_trig = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (hit_valid) seen = 1'b1;
    end
    chk("no_hit_after_rst", seen, 0);
    chk("cal_idle_after_rst", {cal_s0, cal_s1}, 0);
    chk("end_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
